// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ one-byte holding slots.
// Optional build macro UART_ARB_TAG_EN: each grant sends a tag byte (8'hA0 | grant_id) ahead of the payload.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic                 err_timeout,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_finish
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;
    localparam int         CW          = $clog2(START_TIMEOUT + 1);

    logic [1:0]         state;
    logic [1:0]         ptr;
    logic [CW-1:0]      wait_cnt;
    logic [NUM_REQ-1:0] full;
    logic [7:0]         slot_data [NUM_REQ];
    logic               pick_valid;
    logic [1:0]         pick;
    logic [7:0]         pick_data;
    logic               idle_go;
    logic               clear_en;
    logic [1:0]         clear_idx;
`ifdef UART_ARB_TAG_EN
    logic               tag_phase;
    logic [7:0]         grant_data;
`endif

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Scan offsets from the largest down so the slot closest to the pointer wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (full[i] && (i == wrap_idx(int'(ptr) + k))) begin
                    pick_valid = 1'b1;
                    pick       = 2'(i);
                end
            end
        end
    end

    always_comb begin
        pick_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 2'(i)) begin
                pick_data = slot_data[i];
            end
        end
    end

    assign idle_go = (state == S_IDLE) && pick_valid && tx_finish;

`ifdef UART_ARB_TAG_EN
    always_comb begin
        grant_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                grant_data = slot_data[i];
            end
        end
    end

    // The slot is only released once its payload, not the tag, is handed over.
    assign clear_en  = (state == S_WAIT_DONE) && tx_finish && tag_phase;
    assign clear_idx = grant_id;
`else
    assign clear_en  = idle_go;
    assign clear_idx = pick;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_data[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (clear_en && (clear_idx == 2'(i))) begin
                    full[i] <= 1'b0;
                end else if (req_valid[i] && !full[i]) begin
                    full[i]      <= 1'b1;
                    slot_data[i] <= req_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= 2'd0;
            wait_cnt    <= '0;
            grant_id    <= 2'd0;
            tx_data     <= 8'h00;
            done        <= '0;
            err_timeout <= 1'b0;
`ifdef UART_ARB_TAG_EN
            tag_phase   <= 1'b0;
`endif
        end else begin
            done        <= '0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (idle_go) begin
                        grant_id <= pick;
`ifdef UART_ARB_TAG_EN
                        tx_data   <= 8'hA0 | {6'b0, pick};
                        tag_phase <= 1'b1;
`else
                        tx_data   <= pick_data;
`endif
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A transmitter that never leaves idle gets the same byte again.
                    if (!tx_finish) begin
                        state <= S_WAIT_DONE;
                    end else if (wait_cnt == CW'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_LAUNCH;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_finish) begin
`ifdef UART_ARB_TAG_EN
                        if (tag_phase) begin
                            tx_data   <= grant_data;
                            tag_phase <= 1'b0;
                            state     <= S_LAUNCH;
                        end else begin
`else
                        begin
`endif
                            for (int i = 0; i < NUM_REQ; i++) begin
                                done[i] <= (grant_id == 2'(i));
                            end
                            ptr   <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = ~full;
    assign tx_en     = (state == S_LAUNCH);
    assign busy      = (state != S_IDLE);

endmodule
